// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 4-bit ALU between NREQ requesters (optional stat_ops counter: ALU_ARB_STATS_EN)
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_op,
    output logic [2:0]        alu_ctr,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    input  logic [3:0]        alu_result,
    input  logic [3:0]        alu_flags,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [3:0]        rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              busy,
    output logic [7:0]        stat_ops
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   cur_id;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   next_ptr;
    logic            gnt_found;
    logic            handshake;
    int              idx;

    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IW'(idx);
            end
        end
    end

    // Grant is only offered in IDLE; the handshake completes in that same cycle
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == IDLE) && gnt_found && (gnt_id == IW'(i));
        end
    end

    assign next_ptr  = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    assign handshake = (state == RESP) && rsp_ready[cur_id];
    assign busy      = (state != IDLE);

    // Control FSM: issue to the ALU, capture its result, hold the response until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            alu_ctr    <= 3'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            rsp_valid  <= '0;
            rsp_result <= 4'd0;
            rsp_flags  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        alu_ctr <= req_op[3*gnt_id +: 3];
                        alu_a   <= req_a[4*gnt_id +: 4];
                        alu_b   <= req_b[4*gnt_id +: 4];
                        cur_id  <= gnt_id;
                        rr_ptr  <= next_ptr;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_valid  <= NREQ'(1) << cur_id;
                    state      <= RESP;
                end
                RESP: begin
                    if (handshake) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] ops_cnt;

    // Count consumed responses, sticking at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_cnt <= 8'd0;
        end else if (handshake && (ops_cnt != 8'hFF)) begin
            ops_cnt <= ops_cnt + 8'd1;
        end
    end

    assign stat_ops = ops_cnt;
`else
    assign stat_ops = 8'd0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit ALU instance (3-bit op code, 4-bit result, 4-bit flag vector) between NREQ requesters, e.g. switch-panel input and an automatic test-pattern sequencer.
- Round-robin arbitration, per-requester valid/ready request handshake, registered response held until accepted.
- Sits between the requesters and the ALU; the result feeds LED/7-seg display logic downstream.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  NREQ  request i pending
- req_ready  output  NREQ  request i accepted this cycle (one-hot or zero)
- req_a  input  4*NREQ  operand A, requester i at [4i+3:4i]
- req_b  input  4*NREQ  operand B, same packing
- req_op  input  3*NREQ  ALU op code, requester i at [3i+2:3i]
- alu_ctr  output  3  op code to ALU
- alu_a  output  4  operand A to ALU
- alu_b  output  4  operand B to ALU
- alu_result  input  4  ALU result (combinational from alu_*)
- alu_flags  input  4  ALU flag vector, passed through opaquely
- rsp_valid  output  NREQ  response for requester i valid (one-hot or zero)
- rsp_ready  input  NREQ  requester i consumes response
- rsp_result  output  4  captured result
- rsp_flags  output  4  captured flags
- busy  output  1  high in any state except IDLE
- stat_ops  output  8  completed-op count (see Optional Feature)

Behaviour:
- Clock/reset: clk; rst is asynchronous and active-high.
- Reset: state=IDLE, rr_ptr=0; req_ready, rsp_valid, busy, alu_ctr, alu_a, alu_b, rsp_result, rsp_flags, stat_ops all 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant the first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
  - req_ready[g] is asserted combinationally in the same cycle; handshake completes there.
  - On that edge: latch op/a/b of g into the alu_* output registers, store grant id, rr_ptr <= (g+1) mod NREQ, go to EXEC.
  - No req_valid: stay in IDLE; rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - alu_* are stable from registers.
  - At the edge, capture alu_result/alu_flags into rsp_result/rsp_flags and go to RESP.
- RESP:
  - rsp_valid[id]=1, other bits 0.
  - When rsp_ready[id]=1: return to IDLE at that edge; rsp_valid drops next cycle.
  - rsp_ready on other bits is ignored.
- Latency: accept at cycle t, rsp_valid high from t+2. Minimum issue interval is 3 cycles. No new grant until the response is consumed.
- req_ready is 0 in EXEC and RESP regardless of req_valid.
- alu_* and rsp_* hold their last values after completion; they are not cleared.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,..,NREQ-1. A requester waits at most NREQ-1 other grants.
- A requester may drop req_valid before being granted; no state is kept for it.
- Simultaneous rsp_ready and new req_valid in RESP: the request is granted no earlier than the following IDLE cycle.
- Reset asserted mid-operation: immediately returns to IDLE with reset values. The in-flight response is discarded and no rsp_valid pulse is produced.
- Width rules: all operand/result widths are fixed at 4 bits; no extension or truncation inside the block.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - stat_ops is an 8-bit counter incremented on each completed response handshake (RESP with rsp_ready[id]).
  - Saturates at 255; cleared by rst.
- Undefined: stat_ops tied to 0 and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Single request, NREQ=2: req0 op=0 a=3 b=5 with alu model add.
  - req_ready[0] in cycle 0; alu_a=3, alu_b=5 in cycle 1.
  - rsp_valid=01, rsp_result=8 in cycle 2.
- Simultaneous contention: both valid continuously from reset, rsp_ready=11.
  - Grant order 0,1,0,1; each rsp_valid one-hot matches its grant.
  - Results match each requester's operands.
- Backpressure: rsp_ready[0]=0 for 5 cycles while req1 is valid.
  - rsp_valid[0] is held with stable rsp_result/rsp_flags.
  - req_ready stays 00 until rsp_ready[0] rises; req1 is granted the cycle after return to IDLE.
- Flag pass-through: ALU model returns flags=4'b1010, result=0.
  - rsp_flags=1010, rsp_result=0 captured exactly.
- Reset mid-EXEC: assert rst during EXEC.
  - All outputs go to 0 asynchronously; no rsp_valid pulse after rst releases.
  - rr_ptr=0, so req0 wins the next contention.
- ALU_ARB_STATS_EN defined: 300 back-to-back completions → stat_ops=255. Macro undefined → stat_ops=0 throughout.
